mips_register_file: RTL

- 32 x 32-bit MIPS general-purpose register file. Sits directly downstream of the write-enable decoder and consumes its one-hot enable vector.
- Provides two combinational read ports with write-through bypass and one write-back port.
- Includes a per-register busy scoreboard (set at issue, cleared at write-back) that raises Stall for read-after-write hazards on in-flight loads.

---
 rtl/mips_rf_pkg.sv | 13 +
 rtl/dcd_en.sv | 20 ++
 rtl/mips_register_file.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_rf_pkg.sv
// Shared sizing and index/word types for the MIPS general-purpose register file.
package mips_rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/dcd_en.sv
// Write-enable decoder: {en, addr} to a one-hot vector, MSB-first (register i on bit NREGS-1-i).
module dcd_en
    import mips_rf_pkg::*;
(
    input  logic             en,
    input  reg_idx_t         addr,
    output logic [NREGS-1:0] decOut
);

    // Index 0 is the hardwired zero register, so its enable bit is never produced.
    always_comb begin
        decOut = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (en && (addr == reg_idx_t'(i))) begin
                decOut[NREGS-1-i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS register file: two bypassed combinational read ports, one write-back port,
// and a per-register busy scoreboard that stalls reads of in-flight long-latency results.
module mips_register_file
    import mips_rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              MarkBusy,
    input  logic [ADDR_W-1:0] BusyRegister,
    output logic              Stall,
    output logic [NREGS-1:0]  BusyVector
);

    logic [NREGS-1:0] decOut;
    logic [NREGS-1:0] wrEn;
    logic [NREGS-1:0] busy;
    word_t            regFile [NREGS];
    logic             bypass1;
    logic             bypass2;
    logic             hazard1;
    logic             hazard2;

    dcd_en u_dcd_en (
        .en     (RegWrite),
        .addr   (WriteRegister),
        .decOut (decOut)
    );

    always_comb begin
        wrEn = '0;
        for (int i = 0; i < NREGS; i++) begin
            wrEn[i] = decOut[NREGS-1-i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wrEn[i]) begin
                    regFile[i] <= WriteData;
                end
            end
        end
    end

    // A new mark beats a completing write-back: the newer producer still owes a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (MarkBusy && (BusyRegister == reg_idx_t'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wrEn[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign bypass1 = RegWrite && (WriteRegister == ReadRegister1);
    assign bypass2 = RegWrite && (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1 = regFile[ReadRegister1];
        if (reset || (ReadRegister1 == ZERO_REG)) begin
            ReadData1 = '0;
        end else if (bypass1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regFile[ReadRegister2];
        if (reset || (ReadRegister2 == ZERO_REG)) begin
            ReadData2 = '0;
        end else if (bypass2) begin
            ReadData2 = WriteData;
        end
    end

    // busy[0] never sets, so reads of the zero register cannot stall.
    assign hazard1    = busy[ReadRegister1] && !bypass1;
    assign hazard2    = busy[ReadRegister2] && !bypass2;
    assign Stall      = hazard1 || hazard2;
    assign BusyVector = busy;

endmodule
